hd44780_reader: RTL and testbench

Read-cycle engine for the HD44780 4-bit bus. It drives R/W high and the RS/E strobes, and samples two nibbles from the LCD data pins into a byte. The byte is either the busy flag plus address counter (RS=0) or CGRAM/DDRAM data (RS=1). Optional busy-poll mode repeats the BF/AC read until BF clears or a poll limit expires. It sits beside the write controller under hd44780_top; the top muxes lcd_rs/lcd_e and tristates lcd_data whenever o_bus_req is high.

---
 rtl/hd44780_pkg.sv | 26 ++
 rtl/hd44780_state_timer.sv | 48 ++++
 rtl/hd44780_reader.sv | 201 ++++++++++++++++++++
 tb/tb_hd44780_reader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hd44780_pkg.sv
// Shared definitions for the HD44780 4-bit bus controllers.
// Holds the reader state encoding, the default bus timing in 48 MHz clocks
// (shared with the write controller) and the phase-timer width.
package hd44780_pkg;

    localparam int unsigned TIMER_BITS = 8;

    // Default timing, 48 MHz clocks.
    localparam int unsigned T_AS_DFLT      = 3;   // RS/RW setup before E rise
    localparam int unsigned T_EH_DFLT      = 24;  // E high per nibble
    localparam int unsigned T_EL_DFLT      = 24;  // E low per nibble
    localparam int unsigned T_TA_DFLT      = 3;   // turnaround before bus release
    localparam int unsigned MAX_POLLS_DFLT = 255; // BF reads before timeout

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EH1,
        EL1,
        EH2,
        EL2,
        TURN,
        DONE
    } rd_state_e;

endpackage

// File: rtl/hd44780_state_timer.sv
// Phase timer: loads a duration with start_strobe on the entry edge of a
// phase and raises end_strobe during the last cycle of that phase.
// Ports:
//   CLK_I, RST_I  clock, async active-high reset
//   start_strobe  load DAT_I on this edge (duration in clocks, >= 1)
//   DAT_I         phase duration
//   end_strobe    high in the final cycle of the loaded duration
module hd44780_state_timer
    import hd44780_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_BITS
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             start_strobe,
    input  logic [WIDTH-1:0] DAT_I,
    output logic             end_strobe
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             end_q, end_d;

    // cnt holds the cycles remaining after the current one; end fires at zero.
    always_comb begin
        cnt_d = cnt_q;
        end_d = 1'b0;
        if (start_strobe) begin
            cnt_d = DAT_I - WIDTH'(1);
            end_d = (DAT_I == WIDTH'(1));
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
            end_d = (cnt_q == WIDTH'(1));
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            cnt_q <= '0;
            end_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            end_q <= end_d;
        end
    end

    assign end_strobe = end_q;

endmodule

// File: rtl/hd44780_reader.sv
// HD44780 4-bit read-cycle engine. Drives RS, R/W=1 and E, samples two
// nibbles into a byte, and optionally repeats BF/AC reads until BF clears
// or the poll limit is reached.
// Ports:
//   CLK_I, RST_I   clock, async active-high reset
//   start_strobe   request a read (accepted in IDLE or DONE)
//   i_rs, i_poll   RS and poll mode, latched on an accepted start
//   lcd_data_in    DB7..DB4 from the pads
//   lcd_rs/rw/e    LCD control lines
//   o_bus_req      reader owns the bus (data pads must be released)
//   o_busy         operation in progress
//   o_dat          last byte read {first nibble, second nibble}
//   end_strobe     one-cycle completion pulse
//   o_timeout      last poll operation ended with BF still set
module hd44780_reader
    import hd44780_pkg::*;
#(
    parameter int unsigned T_AS      = T_AS_DFLT,
    parameter int unsigned T_EH      = T_EH_DFLT,
    parameter int unsigned T_EL      = T_EL_DFLT,
    parameter int unsigned T_TA      = T_TA_DFLT,
    parameter int unsigned MAX_POLLS = MAX_POLLS_DFLT
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       start_strobe,
    input  logic       i_rs,
    input  logic       i_poll,
    input  logic [3:0] lcd_data_in,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       o_bus_req,
    output logic       o_busy,
    output logic [7:0] o_dat,
    output logic       end_strobe,
    output logic       o_timeout
);

    localparam int unsigned POLL_BITS = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;

    rd_state_e            state_q, state_d;
    logic                 rs_q, rs_d;
    logic                 poll_q, poll_d;
    logic [POLL_BITS-1:0] poll_cnt_q, poll_cnt_d;
    logic                 timeout_q, timeout_d;
    logic [7:0]           dat_q, dat_d;
    logic                 lcd_rs_q, lcd_rs_d;
    logic                 lcd_rw_q, lcd_rw_d;
    logic                 lcd_e_q, lcd_e_d;
    logic                 bus_req_q, bus_req_d;
    logic                 busy_q, busy_d;
    logic                 end_q, end_d;

    logic                  tmr_load_c;
    logic [TIMER_BITS-1:0] tmr_len_c;
    logic                  tmr_end;

    hd44780_state_timer #(
        .WIDTH(TIMER_BITS)
    ) u_timer (
        .CLK_I       (CLK_I),
        .RST_I       (RST_I),
        .start_strobe(tmr_load_c),
        .DAT_I       (tmr_len_c),
        .end_strobe  (tmr_end)
    );

    // Next state, datapath updates and registered output values.
    always_comb begin
        state_d    = state_q;
        rs_d       = rs_q;
        poll_d     = poll_q;
        poll_cnt_d = poll_cnt_q;
        timeout_d  = timeout_q;
        dat_d      = dat_q;
        tmr_load_c = 1'b0;
        tmr_len_c  = TIMER_BITS'(1);

        case (state_q)
            IDLE, DONE: begin
                if (start_strobe) begin
                    rs_d       = i_rs;
                    poll_d     = i_poll;
                    poll_cnt_d = '0;
                    timeout_d  = 1'b0;
                    state_d    = SETUP;
                    tmr_load_c = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (tmr_end) begin
                    state_d    = EH1;
                    tmr_load_c = 1'b1;
                end
            end
            EH1: begin
                if (tmr_end) begin
                    dat_d[7:4] = lcd_data_in;
                    state_d    = EL1;
                    tmr_load_c = 1'b1;
                end
            end
            EL1: begin
                if (tmr_end) begin
                    state_d    = EH2;
                    tmr_load_c = 1'b1;
                end
            end
            EH2: begin
                if (tmr_end) begin
                    dat_d[3:0] = lcd_data_in;
                    state_d    = EL2;
                    tmr_load_c = 1'b1;
                end
            end
            EL2: begin
                if (tmr_end) begin
                    tmr_load_c = 1'b1;
                    // Poll only applies to BF/AC reads; dat_q[7] is BF.
                    if (poll_q && !rs_q && dat_q[7]) begin
                        if (poll_cnt_q < POLL_BITS'(MAX_POLLS - 1)) begin
                            poll_cnt_d = poll_cnt_q + POLL_BITS'(1);
                            state_d    = SETUP;
                        end else begin
                            timeout_d = 1'b1;
                            state_d   = TURN;
                        end
                    end else begin
                        state_d = TURN;
                    end
                end
            end
            TURN: begin
                if (tmr_end) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            SETUP:    tmr_len_c = TIMER_BITS'(T_AS);
            EH1, EH2: tmr_len_c = TIMER_BITS'(T_EH);
            EL1, EL2: tmr_len_c = TIMER_BITS'(T_EL);
            TURN:     tmr_len_c = TIMER_BITS'(T_TA);
            default:  tmr_len_c = TIMER_BITS'(1);
        endcase

        // Outputs are registered against the state being entered so they
        // line up exactly with the state cycles.
        bus_req_d = (state_d inside {SETUP, EH1, EL1, EH2, EL2, TURN});
        busy_d    = bus_req_d;
        lcd_rs_d  = bus_req_d & rs_d;
        lcd_rw_d  = (state_d inside {SETUP, EH1, EL1, EH2, EL2});
        lcd_e_d   = (state_d inside {EH1, EH2});
        end_d     = (state_d == DONE);
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q    <= IDLE;
            rs_q       <= 1'b0;
            poll_q     <= 1'b0;
            poll_cnt_q <= '0;
            timeout_q  <= 1'b0;
            dat_q      <= 8'h00;
            lcd_rs_q   <= 1'b0;
            lcd_rw_q   <= 1'b0;
            lcd_e_q    <= 1'b0;
            bus_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            end_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rs_q       <= rs_d;
            poll_q     <= poll_d;
            poll_cnt_q <= poll_cnt_d;
            timeout_q  <= timeout_d;
            dat_q      <= dat_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_rw_q   <= lcd_rw_d;
            lcd_e_q    <= lcd_e_d;
            bus_req_q  <= bus_req_d;
            busy_q     <= busy_d;
            end_q      <= end_d;
        end
    end

    assign lcd_rs     = lcd_rs_q;
    assign lcd_rw     = lcd_rw_q;
    assign lcd_e      = lcd_e_q;
    assign o_bus_req  = bus_req_q;
    assign o_busy     = busy_q;
    assign o_dat      = dat_q;
    assign end_strobe = end_q;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_hd44780_reader.sv
// Directed bench for hd44780_reader with a small LCD read model that
// presents the high nibble on the first E pulse and the low nibble on the
// second, advancing through a list of bytes per completed read.
module tb_hd44780_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       i_rs;
    logic       i_poll;
    logic [3:0] lcd_data_in;
    logic       lcd_rs, lcd_rw, lcd_e, o_bus_req, o_busy, end_strobe, o_timeout;
    logic [7:0] o_dat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hd44780_reader #(
        .MAX_POLLS(4)
    ) dut (
        .CLK_I       (clk),
        .RST_I       (rst),
        .start_strobe(start),
        .i_rs        (i_rs),
        .i_poll      (i_poll),
        .lcd_data_in (lcd_data_in),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_e       (lcd_e),
        .o_bus_req   (o_bus_req),
        .o_busy      (o_busy),
        .o_dat       (o_dat),
        .end_strobe  (end_strobe),
        .o_timeout   (o_timeout)
    );

    // LCD model and E-line monitor
    logic [7:0] model_bytes [8];
    int         model_len;
    logic       model_clr;
    logic [2:0] rd_idx;
    logic       nib_hi;
    logic       e_prev;
    int         e_rises;
    int         viol_cnt = 0;

    assign lcd_data_in = nib_hi ? model_bytes[rd_idx][7:4] : model_bytes[rd_idx][3:0];

    always @(negedge clk) begin
        if (lcd_e && (!lcd_rw || !o_bus_req)) viol_cnt++;
        if (rst || model_clr) begin
            rd_idx  = 3'd0;
            nib_hi  = 1'b1;
            e_prev  = 1'b0;
            e_rises = 0;
        end else begin
            if (lcd_e && !e_prev) e_rises++;
            if (!lcd_e && e_prev) begin
                if (nib_hi) begin
                    nib_hi = 1'b0;
                end else begin
                    nib_hi = 1'b1;
                    if (int'(rd_idx) < model_len - 1) rd_idx++;
                end
            end
            e_prev = lcd_e;
        end
    end

    task automatic load_model(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input int len);
        model_bytes[0] = b0;
        model_bytes[1] = b1;
        model_bytes[2] = b2;
        model_bytes[3] = b3;
        model_len = len;
        model_clr = 1'b1;
        repeat (2) @(negedge clk);
        model_clr = 1'b0;
    endtask

    // Issue one start and observe until end_strobe; cycle n is the n-th negedge after the start.
    task automatic run_read(input logic rs, input logic poll, input int budget,
                            output int lat, output int first_e, output int e_hi,
                            output int rs_bad, output logic rw1);
        lat = -1; first_e = -1; e_hi = 0; rs_bad = 0; rw1 = 1'b0;
        @(negedge clk);
        i_rs = rs; i_poll = poll; start = 1'b1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                rw1 = lcd_rw;
            end
            if (lcd_e) begin
                e_hi++;
                if (first_e < 0) first_e = n;
            end
            if (o_bus_req && lcd_rs !== rs) rs_bad++;
            if (end_strobe) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; i_rs = 1'b0; i_poll = 1'b0; model_clr = 1'b0;
        model_len = 1;
        for (int i = 0; i < 8; i++) model_bytes[i] = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({lcd_rs, lcd_rw, lcd_e, o_bus_req, o_busy, end_strobe, o_timeout, o_dat} !== 15'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0000",
                     {lcd_rs, lcd_rw, lcd_e, o_bus_req, o_busy, end_strobe, o_timeout, o_dat});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_read();
        int lat, fe, eh, rb; logic rw1;
        load_model(8'hB4, 8'h00, 8'h00, 8'h00, 1);
        run_read(1'b0, 1'b0, 200, lat, fe, eh, rb, rw1);
        checks++; if (rw1 !== 1'b1) begin errors++; $display("FAIL t1_rw_rise got %b required 1", rw1); end
        checks++; if (fe != 4) begin errors++; $display("FAIL t1_first_e got %0d required 4", fe); end
        checks++; if (eh != 48) begin errors++; $display("FAIL t1_e_high_cycles got %0d required 48", eh); end
        checks++; if (lat != 103) begin errors++; $display("FAIL t1_latency got %0d required 103", lat); end
        checks++; if (o_dat !== 8'hB4) begin errors++; $display("FAIL t1_dat got %h required b4", o_dat); end
        checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL t1_timeout got %b required 0", o_timeout); end
        checks++; if ({o_bus_req, o_busy, lcd_rw, lcd_rs} !== 4'b0) begin
            errors++; $display("FAIL t1_done_outputs got %b required 0000", {o_bus_req, o_busy, lcd_rw, lcd_rs});
        end
        checks++; if (e_rises != 2) begin errors++; $display("FAIL t1_e_pulses got %0d required 2", e_rises); end
    endtask

    task automatic test_data_read_poll_ignored();
        int lat, fe, eh, rb; logic rw1;
        load_model(8'hC5, 8'h00, 8'h00, 8'h00, 1);
        run_read(1'b1, 1'b1, 300, lat, fe, eh, rb, rw1);
        checks++; if (lat != 103) begin errors++; $display("FAIL t2_latency got %0d required 103", lat); end
        checks++; if (o_dat !== 8'hC5) begin errors++; $display("FAIL t2_dat got %h required c5", o_dat); end
        checks++; if (rb != 0) begin errors++; $display("FAIL t2_rs_high got %0d bad cycles required 0", rb); end
        checks++; if (e_rises != 2) begin errors++; $display("FAIL t2_e_pulses got %0d required 2", e_rises); end
    endtask

    task automatic test_poll();
        int lat, fe, eh, rb; logic rw1;
        load_model(8'h80, 8'h80, 8'h80, 8'h12, 4);
        run_read(1'b0, 1'b1, 600, lat, fe, eh, rb, rw1);
        checks++; if (lat != 400) begin errors++; $display("FAIL t3_latency got %0d required 400", lat); end
        checks++; if (o_dat !== 8'h12) begin errors++; $display("FAIL t3_dat got %h required 12", o_dat); end
        checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL t3_timeout got %b required 0", o_timeout); end
        checks++; if (e_rises != 8) begin errors++; $display("FAIL t3_e_pulses got %0d required 8", e_rises); end
    endtask

    task automatic test_poll_timeout();
        int lat, fe, eh, rb; logic rw1;
        load_model(8'h80, 8'h00, 8'h00, 8'h00, 1);
        run_read(1'b0, 1'b1, 600, lat, fe, eh, rb, rw1);
        checks++; if (lat != 400) begin errors++; $display("FAIL t4_latency got %0d required 400", lat); end
        checks++; if (o_timeout !== 1'b1) begin errors++; $display("FAIL t4_timeout got %b required 1", o_timeout); end
        checks++; if (o_bus_req !== 1'b0) begin errors++; $display("FAIL t4_bus_req_at_end got %b required 0", o_bus_req); end
        checks++; if (e_rises != 8) begin errors++; $display("FAIL t4_e_pulses got %0d required 8", e_rises); end
        checks++; if (o_dat !== 8'h80) begin errors++; $display("FAIL t4_dat got %h required 80", o_dat); end
        repeat (3) @(negedge clk);
        checks++; if ({o_timeout, end_strobe} !== 2'b10) begin
            errors++; $display("FAIL t4_timeout_hold got %b required 10", {o_timeout, end_strobe});
        end
    endtask

    task automatic test_reset_mid_cycle();
        int lat, fe, eh, rb; logic rw1; logic e_at60; int ends;
        load_model(8'h5A, 8'h00, 8'h00, 8'h00, 1);
        e_at60 = 1'b0; ends = 0;
        @(negedge clk);
        i_rs = 1'b0; i_poll = 1'b0; start = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 60) e_at60 = lcd_e;
        end
        checks++; if (e_at60 !== 1'b1) begin errors++; $display("FAIL t5_in_eh2 got %b required 1", e_at60); end
        rst = 1'b1;
        #1;
        checks++; if ({lcd_e, lcd_rw, o_bus_req, o_busy} !== 4'b0) begin
            errors++; $display("FAIL t5_async_clear got %b required 0000", {lcd_e, lcd_rw, o_bus_req, o_busy});
        end
        checks++; if ({o_timeout, o_dat} !== 9'h0) begin
            errors++; $display("FAIL t5_status_clear got %h required 000", {o_timeout, o_dat});
        end
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (end_strobe) ends++;
        end
        rst = 1'b0;
        for (int n = 0; n < 120; n++) begin
            @(negedge clk);
            if (end_strobe) ends++;
        end
        checks++; if (ends != 0) begin errors++; $display("FAIL t5_no_strobe got %0d required 0", ends); end
        run_read(1'b0, 1'b0, 200, lat, fe, eh, rb, rw1);
        checks++; if (lat != 103) begin errors++; $display("FAIL t5_after_latency got %0d required 103", lat); end
        checks++; if (o_dat !== 8'h5A) begin errors++; $display("FAIL t5_after_dat got %h required 5a", o_dat); end
    endtask

    task automatic test_back_to_back();
        int end1, end2; logic [7:0] dat1; logic rw_a, busy_a;
        load_model(8'h3C, 8'hA7, 8'h00, 8'h00, 2);
        end1 = -1; end2 = -1; dat1 = 8'h00; rw_a = 1'b0; busy_a = 1'b0;
        @(negedge clk);
        i_rs = 1'b0; i_poll = 1'b0; start = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n == 1 || n == 11) start = 1'b0;
            if (n == 10) start = 1'b1;
            if (end1 >= 0 && n == end1 + 1) begin
                start = 1'b0;
                rw_a = lcd_rw;
                busy_a = o_busy;
            end
            if (end_strobe) begin
                if (end1 < 0) begin
                    end1 = n;
                    dat1 = o_dat;
                    start = 1'b1;
                end else begin
                    end2 = n;
                    break;
                end
            end
        end
        checks++; if (end1 != 103) begin errors++; $display("FAIL t6_first_latency got %0d required 103", end1); end
        checks++; if (dat1 !== 8'h3C) begin errors++; $display("FAIL t6_first_dat got %h required 3c", dat1); end
        checks++; if ({rw_a, busy_a} !== 2'b11) begin
            errors++; $display("FAIL t6_restart_next_cycle got %b required 11", {rw_a, busy_a});
        end
        checks++; if (end2 != 206) begin errors++; $display("FAIL t6_second_end got %0d required 206", end2); end
        checks++; if (o_dat !== 8'hA7) begin errors++; $display("FAIL t6_second_dat got %h required a7", o_dat); end
        checks++; if (viol_cnt != 0) begin errors++; $display("FAIL e_with_rw_low got %0d cycles required 0", viol_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_data_read_poll_ignored();
        test_poll();
        test_poll_timeout();
        test_reset_mid_cycle();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
